// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, parity modes and sampling helper
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Two-of-three vote used to settle each bit from its mid-bit samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversampling tick generator, re-phasable by clear
module uart_baud_tick #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int RAW_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (RAW_DIV < 1) ? 1 : RAW_DIV;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Divider counts 0..DIV-1; clear restarts the phase at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !clear && (cnt == LAST);

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - oversampled UART receiver with parity, stop bits and valid/ready output
module uart_rx_framed
  import uart_pkg::*;
#(
  parameter int DATA_SIZE   = 8,
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_line,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OSW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_SIZE);
  localparam logic [OSW-1:0] OS_S0   = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_S1   = OSW'(OVERSAMPLE / 2);
  localparam logic [OSW-1:0] OS_S2   = OSW'(OVERSAMPLE / 2 + 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_SIZE - 1);
  localparam logic           SB_LAST = 1'(STOP_BITS - 1);
  localparam logic           ODD     = 1'(PARITY == PAR_ODD);

  logic                 sync1, rxs, rxs_prev;
  logic                 fall, clear, tick, maj, mid, bit_end;
  uart_state_t          state;
  logic [OSW-1:0]       os_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 stop_cnt;
  logic [1:0]           samp;
  logic [DATA_SIZE-1:0] shreg;
  logic                 fe_acc, pe_acc;

  // Two-stage synchroniser plus edge history, all idling high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= 1'b1;
      rxs      <= 1'b1;
      rxs_prev <= 1'b1;
    end else begin
      sync1    <= rx_line;
      rxs      <= sync1;
      rxs_prev <= rxs;
    end
  end

  assign fall    = rxs_prev && !rxs;
  assign clear   = (state == ST_IDLE) && fall;
  assign maj     = majority3(samp[0], samp[1], rxs);
  assign mid     = tick && (os_cnt == OS_S2);
  assign bit_end = tick && (os_cnt == OS_LAST);

  uart_baud_tick #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE),
    .OVERSAMPLE  (OVERSAMPLE)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // Receive FSM with registered outputs and the output-slot handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      samp       <= 2'b11;
      shreg      <= '0;
      fe_acc     <= 1'b0;
      pe_acc     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (data_valid && data_ready) data_valid <= 1'b0;

      if (tick && (state != ST_IDLE)) begin
        os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OSW'(1);
        if (os_cnt == OS_S0) samp[0] <= rxs;
        if (os_cnt == OS_S1) samp[1] <= rxs;
      end

      case (state)
        ST_IDLE: begin
          if (fall) begin
            state    <= ST_START;
            busy     <= 1'b1;
            os_cnt   <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            fe_acc   <= 1'b0;
            pe_acc   <= 1'b0;
          end
        end
        ST_START: begin
          if (mid && maj) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (bit_end) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mid) shreg <= {maj, shreg[DATA_SIZE-1:1]};
          if (bit_end) begin
            if (bit_cnt == BC_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        ST_PARITY: begin
          if (mid) pe_acc <= (^shreg) ^ maj ^ ODD;
          if (bit_end) state <= ST_STOP;
        end
        ST_STOP: begin
          if (mid) begin
            if (stop_cnt == SB_LAST) begin
              if (!data_valid || data_ready) begin
                data_out   <= shreg;
                frame_err  <= fe_acc | !maj;
                parity_err <= pe_acc;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state    <= ST_IDLE;
              busy     <= 1'b0;
              stop_cnt <= 1'b0;
            end else begin
              fe_acc <= fe_acc | !maj;
            end
          end else if (bit_end) begin
            stop_cnt <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - directed self-checking bench for uart_rx_framed (7N1 and 7E1 instances)
module tb_uart_rx_framed;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_n = 1'b1, rx_e = 1'b1;
  logic       ready_n = 1'b0, ready_e = 1'b0;
  logic [6:0] dout_n, dout_e;
  logic       dv_n, dv_e, fe_n, fe_e, pe_n, pe_e, ovr_n, ovr_e, busy_n, busy_e;

  int total = 0;
  int bad = 0;
  int words_n = 0, words_e = 0, vcyc_n = 0, ovrc_n = 0, ovrc_e = 0;
  logic [6:0] last_n = '0, last_e = '0;
  logic lfe_n = 1'b0, lpe_n = 1'b0, lfe_e = 1'b0, lpe_e = 1'b0;
  int w0, o0;

  always #5 clk = ~clk;

  uart_rx_framed #(
    .DATA_SIZE(7), .CLK_FREQ_HZ(50_000_000), .BAUD_RATE(960000),
    .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)
  ) u_n1 (
    .clk(clk), .reset(reset), .rx_line(rx_n), .data_out(dout_n),
    .data_valid(dv_n), .data_ready(ready_n), .frame_err(fe_n),
    .parity_err(pe_n), .overrun(ovr_n), .busy(busy_n)
  );

  uart_rx_framed #(
    .DATA_SIZE(7), .CLK_FREQ_HZ(50_000_000), .BAUD_RATE(960000),
    .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)
  ) u_e1 (
    .clk(clk), .reset(reset), .rx_line(rx_e), .data_out(dout_e),
    .data_valid(dv_e), .data_ready(ready_e), .frame_err(fe_e),
    .parity_err(pe_e), .overrun(ovr_e), .busy(busy_e)
  );

  // Output monitor: inputs change just after posedge, so negedge values match the next edge
  always @(negedge clk) begin
    if (dv_n) vcyc_n++;
    if (dv_n && ready_n) begin
      words_n++; last_n = dout_n; lfe_n = fe_n; lpe_n = pe_n;
    end
    if (dv_e && ready_e) begin
      words_e++; last_e = dout_e; lfe_e = fe_e; lpe_e = pe_e;
    end
    if (ovr_n) ovrc_n++;
    if (ovr_e) ovrc_e++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_n = v;
    else rx_e = v;
  endtask

  // One 48-clk bit; optional 2-clk inverted spike in the middle of the bit
  task automatic drive_bit(input int which, input logic v, input bit spike);
    set_line(which, v);
    if (spike) begin
      step(24);
      set_line(which, ~v);
      step(2);
      set_line(which, v);
      step(22);
    end else begin
      step(48);
    end
  endtask

  task automatic send_frame(input int which, input logic [6:0] d, input bit has_par,
                            input logic pbit, input logic stop, input int spike_idx);
    drive_bit(which, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) drive_bit(which, d[i], i == spike_idx);
    if (has_par) drive_bit(which, pbit, 1'b0);
    drive_bit(which, stop, 1'b0);
  endtask

  initial begin
    // Reset values
    step(3);
    chk("rst_data", dout_n, 7'h00);
    chk("rst_valid", dv_n, 1'b0);
    chk("rst_fe", fe_n, 1'b0);
    chk("rst_pe", pe_n, 1'b0);
    chk("rst_ovr", ovr_n, 1'b0);
    chk("rst_busy", busy_n, 1'b0);
    reset = 1'b1;
    ready_n = 1'b1;
    ready_e = 1'b1;
    step(10);

    // 7N1, 7'h57, busy three clocks after the falling edge
    rx_n = 1'b0;
    step(2);
    chk("busy_early", busy_n, 1'b0);
    step(1);
    chk("busy_rise", busy_n, 1'b1);
    step(45);
    for (int i = 0; i < 7; i++) drive_bit(0, 7'h57 >> i & 1, 1'b0);
    drive_bit(0, 1'b1, 1'b0);
    chk("n1_words", words_n, 1);
    chk("n1_data", last_n, 7'h57);
    chk("n1_fe", lfe_n, 1'b0);
    chk("n1_pe", lpe_n, 1'b0);
    chk("n1_vcyc", vcyc_n, 1);
    chk("n1_busy_end", busy_n, 1'b0);

    // 7E1: good parity then bad parity
    send_frame(1, 7'h57, 1'b1, 1'b1, 1'b1, -1);
    chk("e1_words", words_e, 1);
    chk("e1_data", last_e, 7'h57);
    chk("e1_pe_ok", lpe_e, 1'b0);
    chk("e1_fe_ok", lfe_e, 1'b0);
    send_frame(1, 7'h57, 1'b1, 1'b0, 1'b1, -1);
    chk("e1_words2", words_e, 2);
    chk("e1_data2", last_e, 7'h57);
    chk("e1_pe_bad", lpe_e, 1'b1);

    // Break: stop bit 0, then line held low for 20 bit periods
    w0 = words_n;
    send_frame(0, 7'h00, 1'b0, 1'b0, 1'b0, -1);
    chk("brk_words", words_n, w0 + 1);
    chk("brk_data", last_n, 7'h00);
    chk("brk_fe", lfe_n, 1'b1);
    step(20 * 48);
    chk("brk_hold_words", words_n, w0 + 1);
    chk("brk_hold_busy", busy_n, 1'b0);
    rx_n = 1'b1;
    step(96);
    send_frame(0, 7'h2A, 1'b0, 1'b0, 1'b1, -1);
    chk("brk_after_words", words_n, w0 + 2);
    chk("brk_after_data", last_n, 7'h2A);
    chk("brk_after_fe", lfe_n, 1'b0);

    // Overrun with the consumer stalled
    ready_n = 1'b0;
    w0 = words_n;
    o0 = ovrc_n;
    send_frame(0, 7'h11, 1'b0, 1'b0, 1'b1, -1);
    send_frame(0, 7'h22, 1'b0, 1'b0, 1'b1, -1);
    chk("ovr_pulses", ovrc_n, o0 + 1);
    chk("ovr_hold_data", dout_n, 7'h11);
    chk("ovr_hold_valid", dv_n, 1'b1);
    ready_n = 1'b1;
    step(1);
    chk("ovr_accept_words", words_n, w0 + 1);
    chk("ovr_accept_data", last_n, 7'h11);
    chk("ovr_valid_fall", dv_n, 1'b0);

    // False start: 16-clk low glitch
    step(50);
    w0 = words_n;
    rx_n = 1'b0;
    step(5);
    chk("fs_busy_high", busy_n, 1'b1);
    step(11);
    rx_n = 1'b1;
    step(60);
    chk("fs_busy_low", busy_n, 1'b0);
    chk("fs_no_word", words_n, w0);

    // 2-clk spike mid data bit 2 is voted out
    send_frame(0, 7'h35, 1'b0, 1'b0, 1'b1, 2);
    chk("spk_words", words_n, w0 + 1);
    chk("spk_data", last_n, 7'h35);
    chk("spk_fe", lfe_n, 1'b0);

    // Reset during data bit 3
    w0 = words_n;
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive_bit(0, 7'h3C >> i & 1, 1'b0);
    rx_n = 1'b1;
    step(20);
    reset = 1'b0;
    step(2);
    chk("mid_rst_data", dout_n, 7'h00);
    chk("mid_rst_valid", dv_n, 1'b0);
    chk("mid_rst_busy", busy_n, 1'b0);
    chk("mid_rst_fe", fe_n, 1'b0);
    chk("mid_rst_e1_data", dout_e, 7'h00);
    reset = 1'b1;
    step(200);
    chk("mid_rst_no_word", words_n, w0);
    send_frame(0, 7'h3C, 1'b0, 1'b0, 1'b1, -1);
    chk("post_rst_words", words_n, w0 + 1);
    chk("post_rst_data", last_n, 7'h3C);
    chk("post_rst_fe", lfe_n, 1'b0);
    chk("pe_never_n1", pe_n, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framed.md
# uart_rx_framed

Parametrised UART receiver, the successor to the fixed 8N1-style receive path inside `UART`. It adds configurable parity (none/even/odd), one or two stop bits, 3-sample majority voting, and a valid/ready output handshake. Words carry per-word framing and parity error flags, and an overrun pulse reports dropped words. It sits between an asynchronous `rx_line` pin and any clocked consumer (FIFO, command decoder).

## Interface
- `DATA_SIZE`, 8: data bits per frame, 5..9, LSB first.
- `CLK_FREQ_HZ`, 50_000_000: `clk` frequency.
- `BAUD_RATE`, 115200: line bit rate.
- `OVERSAMPLE`, 16: ticks per bit, even, ≥8.
- `PARITY`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: 1 or 2.

- `clk` in 1: single clock.
- `reset` in 1: **asynchronous, active-low** reset. Low means in reset.
- `rx_line` in 1: serial input, asynchronous, idles high.
- `data_out` out DATA_SIZE: received word, stable while `data_valid` is high.
- `data_valid` out 1: word available.
- `data_ready` in 1: consumer accepts the word when `data_valid && data_ready` at a `clk` edge.
- `frame_err` out 1: qualified by `data_valid`. A stop bit was sampled 0.
- `parity_err` out 1: qualified by `data_valid`. Parity mismatch; always 0 when `PARITY==0`.
- `overrun` out 1: one-cycle pulse when a completed word is dropped.
- `busy` out 1: high in every state except IDLE.

## Operation
- **Tick generator.** `DIV = max(1, CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE))`, integer truncated. One tick every DIV clocks.
- **Synchroniser.** Two flops on `rx_line`, both reset to 1. `rxs` is the synchronised signal.
- **State machine:** IDLE → START → DATA → PARITY (skipped if `PARITY==0`) → STOP → IDLE.
- **IDLE.** A falling edge on `rxs` (previous 1, now 0) moves to START. It also clears the divider and the tick counter `os_cnt`, so ticks are phase-aligned to the edge.
- **Sampling.**
  - Within each bit, `os_cnt` counts 0..OVERSAMPLE-1.
  - `rxs` is captured at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1.
  - The bit value is the majority of the three, valid after the third capture.
- **START.** A majority of 1 means a false start: return to IDLE with no output. Otherwise continue to DATA at `os_cnt==OVERSAMPLE-1`.
- **DATA.** Shift DATA_SIZE bits LSB first; the bit counter wraps to 0 on exit.
- **PARITY.** Even parity: XOR of the data bits and the parity bit must be 0. Odd parity: it must be 1.
- **STOP.**
  - Each stop bit is majority-sampled; any 0 sets `frame_err`.
  - After the majority of the final stop bit, the word is committed and the FSM returns to IDLE immediately, without waiting for the bit end. This allows back-to-back frames.
- **Commit.**
  - If the output slot is empty, or is being emptied by a handshake in the same cycle: load `data_out` and both error flags, and set `data_valid`.
  - Otherwise: the new word is discarded, the old word and flags are kept, and `overrun` pulses for one cycle.
- **Error words.** Framing and parity errors do not suppress delivery. A break (all zeros) is delivered as 0 with `frame_err=1`.
- **Line held low.** After a break, no new start is detected until `rxs` has been seen high.

## Timing
- **Reset values.** `data_out=0`, `data_valid=0`, `frame_err=0`, `parity_err=0`, `overrun=0`, `busy=0`. FSM in IDLE, all counters 0.
- **Reset mid-frame.** The frame is aborted with no output.
- **Low line at reset release.** Treated as a start edge, because the synchroniser resets to 1.
- **Edge to `busy`.** `busy` rises 3 `clk` after the `rx_line` falling edge (2 sync flops + 1 state register).
- **Commit latency.** `data_valid` rises on the `clk` after the final stop-bit majority: about (1+DATA_SIZE+P+STOP_BITS-0.5) bit periods after the start edge, plus 3 clk, where P = 1 if parity is enabled, else 0.
- **Clearing `data_valid`.** It falls on the `clk` after the handshake, unless a commit occurs in the same cycle, in which case it stays high with the new word.
- **Handshake rule.** `data_valid` never drops without a handshake. `data_out` and the flags do not change while `data_valid && !data_ready`.

## Structure
- **Package `uart_pkg`:** state encodings (IDLE, START, DATA, PARITY, STOP) and parity mode constants (`PAR_NONE=0`, `PAR_EVEN=1`, `PAR_ODD=2`). The package is shared with the future matching transmitter.
- **Sub-module `uart_baud_tick`:** parameters CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE; inputs `clk`, `reset`, `clear`; output `tick`. The transmitter reuses it.

## Test plan
All scenarios use DATA_SIZE=7, CLK 50 MHz, BAUD 960000, OVERSAMPLE 16, giving DIV=3 and a bit period of 48 clk.
- **7N1, ready held high:** send 7'b1010111. `data_out=7'h57`, `data_valid` for 1 clk, no error flags.
- **7E1:** send 7'h57 (five 1s) with parity bit 1 → no error. Resend with parity bit 0 → `parity_err=1`, data still 7'h57.
- **Break:** hold stop bit 0 → `frame_err=1`. Then hold the line low for 20 bit periods → no second word until the line returns high and a new start bit arrives.
- **Overrun, `data_ready=0`:** send 7'h11 then 7'h22 back-to-back. `data_out` stays 7'h11 and `overrun` pulses once. Raise `data_ready` → 7'h11 accepted, `data_valid` falls.
- **False start:** a 16-clk low glitch → `busy` returns to 0 with no `data_valid`. Then a 2-clk low spike in the middle of a data bit → majority voting gives the correct word.
- **Reset mid-frame:** pull `reset` low during bit 3 → all outputs 0. A clean frame 7'h3C sent after release is received correctly.
